// File: rtl/rs232c_tx_fifo.sv
// Byte FIFO feeding an RS-232C transmitter through its TX_DATA/TX_DATA_EN/TX_BUSY handshake.
// Optional macro RS232C_TXF_CRLF_EN: an LF at the head is sent as CR then LF.
module rs232c_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RESETB,
  input  logic [7:0]            WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVF,
  input  logic                  OVF_CLR,
  output logic [7:0]            TX_DATA,
  output logic                  TX_DATA_EN,
  input  logic                  TX_BUSY
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt_nxt;
  logic                  wr_ok, pop, cr_insert;

`ifdef RS232C_TXF_CRLF_EN
  logic cr_pending;
  always_comb begin
    cr_insert = 1'b0;
    if (mem[rd_ptr] == 8'h0A && !cr_pending) cr_insert = 1'b1;
  end
`else
  always_comb cr_insert = 1'b0;
`endif

  // Acceptance is judged on the registered FULL, so a pop cannot make room this cycle.
  always_comb begin
    wr_ok = WR_EN && !FULL;
    pop   = (state == IDLE) && !EMPTY && !cr_insert;
    case ({wr_ok, pop})
      2'b10:   cnt_nxt = COUNT + CNT_ONE;
      2'b01:   cnt_nxt = COUNT - CNT_ONE;
      default: cnt_nxt = COUNT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= WR_DATA;
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
      FULL   <= 1'b0;
      EMPTY  <= 1'b1;
      OVF    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      COUNT <= cnt_nxt;
      FULL  <= (cnt_nxt == CNT_FULL);
      EMPTY <= (cnt_nxt == '0);
      if (WR_EN && FULL) OVF <= 1'b1;
      else if (OVF_CLR)  OVF <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state      <= IDLE;
      TX_DATA    <= 8'h00;
      TX_DATA_EN <= 1'b0;
`ifdef RS232C_TXF_CRLF_EN
      cr_pending <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!EMPTY) begin
            state      <= ISSUE;
            TX_DATA_EN <= 1'b1;
`ifdef RS232C_TXF_CRLF_EN
            if (cr_insert) begin
              TX_DATA    <= 8'h0D;
              cr_pending <= 1'b1;
            end else begin
              TX_DATA    <= mem[rd_ptr];
              cr_pending <= 1'b0;
            end
`else
            TX_DATA <= mem[rd_ptr];
`endif
          end
        end
        ISSUE: begin
          TX_DATA_EN <= 1'b0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: if (TX_BUSY) state <= WAIT_DONE;
        WAIT_DONE: if (!TX_BUSY) state <= IDLE;
        default: begin
          state      <= IDLE;
          TX_DATA_EN <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rs232c_tx_fifo.sv
// Randomized bench for rs232c_tx_fifo with a behavioural transmitter and queue-based reference.
module tb_rs232c_tx_fifo;
  localparam int DL = 4;
  localparam int DEPTH = 16;

  logic CLK = 1'b0, RESETB = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic WR_EN = 1'b0, OVF_CLR = 1'b0, TX_BUSY;
  logic FULL, EMPTY, OVF, TX_DATA_EN;
  logic [DL:0] COUNT;
  logic [7:0] TX_DATA;

  rs232c_tx_fifo #(.DEPTH_LOG2(DL)) dut (
    .CLK(CLK), .RESETB(RESETB), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
    .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVF(OVF), .OVF_CLR(OVF_CLR),
    .TX_DATA(TX_DATA), .TX_DATA_EN(TX_DATA_EN), .TX_BUSY(TX_BUSY)
  );

  always #5 CLK = ~CLK;

  int errors = 0, checks = 0, cyc = 0;
  int frame_len = 4, bcnt, en_busy = 0;
  bit hold = 1'b0, busy_d = 1'b0;
  byte unsigned obs_q[$], exp_q[$];
  int obs_t[$], fall_t[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Transmitter stand-in: busy rises the cycle after the start pulse, lasts frame_len cycles
  always @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      TX_BUSY <= 1'b0;
      bcnt    <= 0;
    end else if (TX_DATA_EN) begin
      TX_BUSY <= 1'b1;
      bcnt    <= frame_len;
    end else if (TX_BUSY) begin
      if (bcnt > 1) bcnt <= bcnt - 1;
      else if (!hold) TX_BUSY <= 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (RESETB) begin
      if (TX_DATA_EN) begin
        obs_q.push_back(TX_DATA);
        obs_t.push_back(cyc);
        if (TX_BUSY) en_busy++;
      end
      if (busy_d && !TX_BUSY) fall_t.push_back(cyc);
    end
    busy_d = TX_BUSY;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  function automatic byte unsigned rb();
    byte unsigned b;
    do b = 8'($urandom); while (b == 8'h0A || b == 8'h00);
    return b;
  endfunction

  task automatic wr(input byte unsigned d);
    WR_DATA = d;
    WR_EN = 1'b1;
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic clear_q();
    obs_q.delete(); obs_t.delete(); fall_t.delete(); exp_q.delete();
  endtask

  task automatic wait_obs(input int n, input string nm);
    int k = 0;
    while (obs_q.size() < n && k < 5000) begin tick(); k++; end
    checks++;
    if (obs_q.size() < n) begin
      errors++;
      $display("FAIL %s wait_pulses: got %0d pulses, want %0d", nm, obs_q.size(), n);
    end
  endtask

  task automatic wait_fall(input string nm);
    int k = 0;
    while (TX_BUSY && k < 5000) begin tick(); k++; end
    checks++;
    if (TX_BUSY) begin errors++; $display("FAIL %s wait_busy_low: TX_BUSY stuck at 1, want 0", nm); end
  endtask

  task automatic wait_quiet(input string nm);
    int k = 0;
    while (!(EMPTY && !TX_BUSY && !TX_DATA_EN) && k < 5000) begin tick(); k++; end
    repeat (4) tick();
    checks++;
    if (!(EMPTY && !TX_BUSY && !TX_DATA_EN)) begin
      errors++;
      $display("FAIL %s drain: EMPTY=%0b TX_BUSY=%0b, want 1/0", nm, EMPTY, TX_BUSY);
    end
  endtask

  task automatic test_reset();
    RESETB = 1'b0;
    repeat (3) tick();
    checks += 6;
    if (FULL !== 1'b0)       begin errors++; $display("FAIL reset_full got %b want 0", FULL); end
    if (EMPTY !== 1'b1)      begin errors++; $display("FAIL reset_empty got %b want 1", EMPTY); end
    if (COUNT !== '0)        begin errors++; $display("FAIL reset_count got %0d want 0", COUNT); end
    if (OVF !== 1'b0)        begin errors++; $display("FAIL reset_ovf got %b want 0", OVF); end
    if (TX_DATA !== 8'h00)   begin errors++; $display("FAIL reset_txdata got %h want 00", TX_DATA); end
    if (TX_DATA_EN !== 1'b0) begin errors++; $display("FAIL reset_txen got %b want 0", TX_DATA_EN); end
    RESETB = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int w;
    clear_q();
    frame_len = 3;
    w = cyc;
    wr(8'h55);
    checks += 2;
    if (EMPTY !== 1'b0) begin errors++; $display("FAIL single_empty_after_store got %b want 0", EMPTY); end
    if (COUNT !== 1)    begin errors++; $display("FAIL single_count got %0d want 1", COUNT); end
    tick();
    checks += 3;
    if (TX_DATA_EN !== 1'b1) begin errors++; $display("FAIL single_en got %b want 1", TX_DATA_EN); end
    if (TX_DATA !== 8'h55)   begin errors++; $display("FAIL single_data got %h want 55", TX_DATA); end
    if (EMPTY !== 1'b1)      begin errors++; $display("FAIL single_empty_on_pop got %b want 1", EMPTY); end
    wait_quiet("single");
    checks += 2;
    if (obs_q.size() != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", obs_q.size()); end
    else if (obs_t[0] != w + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", obs_t[0] - w, 2); end
    if (TX_DATA !== 8'h55) begin errors++; $display("FAIL single_hold got %h want 55", TX_DATA); end
  endtask

  task automatic test_burst();
    clear_q();
    frame_len = $urandom_range(2, 12);
    exp_q.push_back(8'h7E);
    wr(8'h7E);
    wait_obs(1, "burst");
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'h41 + i));
      wr(8'(8'h41 + i));
    end
    checks++;
    if (COUNT !== 4) begin errors++; $display("FAIL burst_count got %0d want 4", COUNT); end
    hold = 1'b0;
    wait_obs(5, "burst");
    wait_quiet("burst");
    checks++;
    if (obs_q.size() != 5) begin errors++; $display("FAIL burst_pulses got %0d want 5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL burst_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 1; i < 5 && i < obs_t.size() && i <= fall_t.size(); i++) begin
      checks++;
      if (obs_t[i] != fall_t[i-1] + 2) begin
        errors++; $display("FAIL burst_spacing[%0d] got %0d want %0d cycles after busy fall", i, obs_t[i] - fall_t[i-1], 2);
      end
    end
  endtask

  task automatic test_overflow();
    byte unsigned d;
    clear_q();
    frame_len = 2;
    exp_q.push_back(8'hF0);
    wr(8'hF0);
    wait_obs(1, "ovf");
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      d = rb(); exp_q.push_back(d); wr(d);
    end
    checks += 3;
    if (FULL !== 1'b1)  begin errors++; $display("FAIL ovf_full got %b want 1", FULL); end
    if (COUNT !== 16)   begin errors++; $display("FAIL ovf_count16 got %0d want 16", COUNT); end
    if (OVF !== 1'b0)   begin errors++; $display("FAIL ovf_early got %b want 0", OVF); end
    wr(rb());
    checks += 2;
    if (OVF !== 1'b1)   begin errors++; $display("FAIL ovf_set got %b want 1", OVF); end
    if (COUNT !== 16)   begin errors++; $display("FAIL ovf_dropped got %0d want 16", COUNT); end
    OVF_CLR = 1'b1; tick(); OVF_CLR = 1'b0;
    checks++;
    if (OVF !== 1'b0)   begin errors++; $display("FAIL ovf_clr got %b want 0", OVF); end
    // A write at FULL lined up with the pop edge must still be rejected
    hold = 1'b0;
    wait_fall("ovf");
    tick();
    WR_DATA = rb(); WR_EN = 1'b1;
    tick();
    WR_EN = 1'b0;
    checks += 4;
    if (TX_DATA_EN !== 1'b1) begin errors++; $display("FAIL ovf_pop_edge got %b want 1", TX_DATA_EN); end
    if (COUNT !== 15)        begin errors++; $display("FAIL ovf_pop_count got %0d want 15", COUNT); end
    if (OVF !== 1'b1)        begin errors++; $display("FAIL ovf_pop_reject got %b want 1", OVF); end
    if (FULL !== 1'b0)       begin errors++; $display("FAIL ovf_pop_full got %b want 0", FULL); end
    wait_obs(17, "ovf");
    wait_quiet("ovf");
    checks++;
    if (obs_q.size() != 17) begin errors++; $display("FAIL ovf_pulses got %0d want 17", obs_q.size()); end
    for (int i = 0; i < 17 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_simul();
    byte unsigned d;
    clear_q();
    frame_len = 3;
    exp_q.push_back(8'h11);
    wr(8'h11);
    wait_obs(1, "simul");
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin d = rb(); exp_q.push_back(d); wr(d); end
    checks++;
    if (COUNT !== 5) begin errors++; $display("FAIL simul_pre got %0d want 5", COUNT); end
    hold = 1'b0;
    wait_fall("simul");
    tick();
    d = rb(); exp_q.push_back(d);
    WR_DATA = d; WR_EN = 1'b1;
    tick();
    WR_EN = 1'b0;
    checks += 2;
    if (TX_DATA_EN !== 1'b1) begin errors++; $display("FAIL simul_pop got %b want 1", TX_DATA_EN); end
    if (COUNT !== 5)         begin errors++; $display("FAIL simul_count got %0d want 5", COUNT); end
    wait_obs(7, "simul");
    wait_quiet("simul");
    checks++;
    if (obs_q.size() != 7) begin errors++; $display("FAIL simul_pulses got %0d want 7", obs_q.size()); end
    for (int i = 0; i < 7 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL simul_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    int nacc = 0, n = 0, mc, k = 0;
    byte unsigned d;
    clear_q();
    frame_len = $urandom_range(1, 6);
    while (k < 3000 && !(n == 40 && obs_q.size() == 40)) begin
      tick(); k++;
      WR_EN = 1'b0;
      mc = nacc - obs_q.size();
      checks++;
      if (COUNT !== mc) begin errors++; $display("FAIL wrap_count got %0d want %0d", COUNT, mc); end
      if (n < 40 && mc < DEPTH && $urandom_range(0, 2) != 0) begin
        d = rb(); exp_q.push_back(d);
        WR_DATA = d; WR_EN = 1'b1;
        n++; nacc++;
      end
    end
    WR_EN = 1'b0;
    wait_quiet("wrap");
    checks++;
    if (obs_q.size() != 40) begin errors++; $display("FAIL wrap_pulses got %0d want 40", obs_q.size()); end
    for (int i = 0; i < 40 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_lf();
    clear_q();
    frame_len = 3;
    wr(8'h0A);
`ifdef RS232C_TXF_CRLF_EN
    tick();
    checks += 3;
    if (TX_DATA_EN !== 1'b1) begin errors++; $display("FAIL crlf_en got %b want 1", TX_DATA_EN); end
    if (TX_DATA !== 8'h0D)   begin errors++; $display("FAIL crlf_cr got %h want 0d", TX_DATA); end
    if (COUNT !== 1)         begin errors++; $display("FAIL crlf_count1 got %0d want 1", COUNT); end
    wait_obs(2, "crlf");
    checks += 2;
    if (TX_DATA !== 8'h0A) begin errors++; $display("FAIL crlf_lf got %h want 0a", TX_DATA); end
    if (COUNT !== 0)       begin errors++; $display("FAIL crlf_count0 got %0d want 0", COUNT); end
    wait_quiet("crlf");
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL crlf_pulses got %0d want 2", obs_q.size()); end
`else
    wait_obs(1, "lf");
    wait_quiet("lf");
    checks += 2;
    if (obs_q.size() != 1) begin errors++; $display("FAIL lf_pulses got %0d want 1", obs_q.size()); end
    if (TX_DATA !== 8'h0A) begin errors++; $display("FAIL lf_verbatim got %h want 0a", TX_DATA); end
`endif
  endtask

  task automatic test_reset_mid();
    int sz;
    clear_q();
    frame_len = 3;
    wr(8'hC3);
    wait_obs(1, "rstmid");
    hold = 1'b1;
    for (int i = 0; i < 3; i++) wr(rb());
    checks += 2;
    if (COUNT !== 3)      begin errors++; $display("FAIL rstmid_count got %0d want 3", COUNT); end
    if (TX_BUSY !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", TX_BUSY); end
    RESETB = 1'b0;
    #1;
    checks += 6;
    if (FULL !== 1'b0)       begin errors++; $display("FAIL rstmid_full got %b want 0", FULL); end
    if (EMPTY !== 1'b1)      begin errors++; $display("FAIL rstmid_empty got %b want 1", EMPTY); end
    if (COUNT !== '0)        begin errors++; $display("FAIL rstmid_cnt got %0d want 0", COUNT); end
    if (OVF !== 1'b0)        begin errors++; $display("FAIL rstmid_ovf got %b want 0", OVF); end
    if (TX_DATA !== 8'h00)   begin errors++; $display("FAIL rstmid_txdata got %h want 00", TX_DATA); end
    if (TX_DATA_EN !== 1'b0) begin errors++; $display("FAIL rstmid_txen got %b want 0", TX_DATA_EN); end
    tick();
    hold = 1'b0;
    RESETB = 1'b1;
    sz = obs_q.size();
    repeat (30) tick();
    checks += 2;
    if (obs_q.size() != sz) begin errors++; $display("FAIL rstmid_no_issue got %0d pulses want 0", obs_q.size() - sz); end
    if (EMPTY !== 1'b1)     begin errors++; $display("FAIL rstmid_after got %b want 1", EMPTY); end
  endtask

  task automatic test_no_en_while_busy();
    checks++;
    if (en_busy != 0) begin errors++; $display("FAIL en_while_busy got %0d pulses want 0", en_busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simul();
    test_wrap();
    test_lf();
    test_reset_mid();
    test_no_en_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
